// File: rtl/key_expansion_sequencer_pkg.sv
// Shared AES key-schedule constants and GF(2^8) helpers used by the
// expansion sequencer and its SubWord block.
package aes_key_pkg;

  localparam logic [1:0] KT_128 = 2'd0;
  localparam logic [1:0] KT_192 = 2'd1;
  localparam logic [1:0] KT_256 = 2'd2;
  localparam logic [1:0] KT_ILL = 2'd3;

  localparam int TOTAL_WORDS_MAX = 60;

  function automatic logic [3:0] nk_of(input logic [1:0] kt);
    case (kt)
      KT_192:  return 4'd6;
      KT_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kt);
    case (kt)
      KT_192:  return 4'd12;
      KT_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s;
    logic [7:0] r;
    s = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/key_expansion_sequencer_subword.sv
// Four parallel S-boxes forming the AES SubWord transform.
module key_expansion_sequencer_subword
  import aes_key_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout[31:24] = sbox(din[31:24]);
  assign dout[23:16] = sbox(din[23:16]);
  assign dout[15:8]  = sbox(din[15:8]);
  assign dout[7:0]   = sbox(din[7:0]);

endmodule

// File: rtl/key_expansion_sequencer.sv
// Iterative AES-128/192/256 key expansion into a 60-word store, one word per
// cycle through a shared SubWord block, with a registered round-key read port.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | no valid schedule, waiting for start
//   ST_EXPAND | generating w[idx] each cycle
//   ST_DONE   | schedule valid, round-key reads served
module key_expansion_sequencer
  import aes_key_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_type,
  input  logic [255:0] key,
  output logic         busy,
  output logic         done,
  output logic         key_err,
  input  logic         rk_rd_en,
  input  logic [3:0]   rk_rd_round,
  output logic         rk_rd_valid,
  output logic [127:0] rk_rd_data
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]   state;
  logic [3:0]   nk;
  logic [3:0]   nr;
  logic [3:0]   phase;
  logic [5:0]   idx;
  logic [5:0]   last_idx;
  logic [7:0]   rcon;
  logic [31:0]  w [TOTAL_WORDS_MAX];

  logic         accept;
  logic         expanding;
  logic         rd_ok;
  logic [31:0]  w_prev;
  logic [31:0]  w_back;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  temp;
  logic [31:0]  w_new;
  logic [5:0]   rbase;
  logic [127:0] rd_word;

  assign expanding = (state == ST_EXPAND);
  assign accept    = start && !expanding && (key_type != KT_ILL);
  assign rd_ok     = rk_rd_en && (state == ST_DONE);
  assign busy      = expanding;
  assign done      = (state == ST_DONE);

  // phase tracks idx mod Nk so no divider is needed
  assign w_prev = w[idx - 6'd1];
  assign w_back = w[idx - {2'b00, nk}];
  assign sub_in = (phase == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  key_expansion_sequencer_subword u_subword (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    temp = w_prev;
    if (phase == 4'd0)
      temp = sub_out ^ {rcon, 24'h000000};
    else if (nk == 4'd8 && phase == 4'd4)
      temp = sub_out;
  end

  assign w_new = w_back ^ temp;

  assign rbase   = {rk_rd_round, 2'b00};
  assign rd_word = {w[rbase + 6'd3], w[rbase + 6'd2], w[rbase + 6'd1], w[rbase]};

  // Store is deliberately not reset; reads are gated by ST_DONE instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        for (int k = 0; k < 8; k++) begin
          if (4'(k) < nk_of(key_type)) w[k] <= key[32*k +: 32];
        end
      end else if (expanding) begin
        w[idx] <= w_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      key_err     <= 1'b0;
      rk_rd_valid <= 1'b0;
      rk_rd_data  <= '0;
    end else begin
      key_err     <= start && !expanding && (key_type == KT_ILL);
      rk_rd_valid <= rd_ok;
      if (rd_ok)
        rk_rd_data <= (rk_rd_round <= nr) ? rd_word : '0;

      if (accept) begin
        state    <= ST_EXPAND;
        nk       <= nk_of(key_type);
        nr       <= nr_of(key_type);
        last_idx <= {nr_of(key_type), 2'b00} + 6'd3;
        idx      <= {2'b00, nk_of(key_type)};
        rcon     <= 8'h01;
        phase    <= 4'd0;
      end else if (expanding) begin
        idx   <= idx + 6'd1;
        phase <= (phase == nk - 4'd1) ? 4'd0 : phase + 4'd1;
        if (phase == 4'd0) rcon <= xtime(rcon);
        if (idx == last_idx) state <= ST_DONE;
      end
    end
  end

endmodule

// File: tb/tb_key_expansion_sequencer.sv
// Randomized scoreboard bench for key_expansion_sequencer against a table-driven
// key-schedule model and the FIPS-197 appendix A vectors.
module tb_key_expansion_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   key_type = 2'd0;
  logic [255:0] key = '0;
  logic         busy, done, key_err;
  logic         rk_rd_en = 1'b0;
  logic [3:0]   rk_rd_round = 4'd0;
  logic         rk_rd_valid;
  logic [127:0] rk_rd_data;

  key_expansion_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .key_type(key_type), .key(key),
    .busy(busy), .done(done), .key_err(key_err),
    .rk_rd_en(rk_rd_en), .rk_rd_round(rk_rd_round),
    .rk_rd_valid(rk_rd_valid), .rk_rd_data(rk_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] exp;
    logic [127:0] mask;
    string        nm;
  } rd_t;

  rd_t rdq[$];
  int  total = 0;
  int  bad = 0;

  localparam logic [127:0] FULL = '1;

  logic [7:0] sbox_t [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  logic [7:0] rcon_t [10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

  // reference schedule of the most recent accepted expansion
  logic [31:0] mw [60];
  int          m_nr = 10;

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  task automatic model_expand(input int kt, input logic [255:0] k);
    int nk;
    logic [31:0] t;
    nk   = 4 + 2 * kt;
    m_nr = nk + 6;
    for (int i = 0; i < nk; i++) mw[i] = k[32*i +: 32];
    for (int i = nk; i < 4 * (m_nr + 1); i++) begin
      t = mw[i-1];
      if (i % nk == 0)
        t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/nk - 1], 24'h0};
      else if (nk == 8 && i % nk == 4)
        t = subw(t);
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_round(input int r);
    if (r > m_nr) return '0;
    return {mw[4*r+3], mw[4*r+2], mw[4*r+1], mw[4*r]};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // monitor: pops one expectation per response; also checks data hold
  initial begin
    rd_t e;
    logic [127:0] last;
    last = '0;
    forever begin
      @(negedge clk);
      if (rk_rd_valid) begin
        total++;
        if (rdq.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected got=%h exp=none", rk_rd_data);
        end else begin
          e = rdq.pop_front();
          if (((rk_rd_data ^ e.exp) & e.mask) != '0) begin
            bad++;
            $display("FAIL %s got=%h exp=%h mask=%h", e.nm, rk_rd_data, e.exp, e.mask);
          end
        end
        last = rk_rd_data;
      end else if (!rst) begin
        total++;
        if (rk_rd_data !== last) begin
          bad++;
          $display("FAIL rd_hold got=%h exp=%h", rk_rd_data, last);
        end
      end else begin
        last = '0;
      end
    end
  end

  task automatic rd_issue(input int r, input logic [127:0] exp, input logic [127:0] mask,
                          input string nm);
    @(negedge clk);
    rk_rd_en    = 1'b1;
    rk_rd_round = 4'(r);
    rdq.push_back('{exp: exp, mask: mask, nm: nm});
  endtask

  task automatic rd_stop();
    @(negedge clk);
    rk_rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_blocked(input string nm);
    @(negedge clk);
    rk_rd_en    = 1'b1;
    rk_rd_round = 4'($urandom_range(0, 10));
    @(negedge clk);
    rk_rd_en = 1'b0;
    chk(nm, rk_rd_valid, 0);
  endtask

  // start an expansion; optional same-cycle read and mid-expansion start
  task automatic do_expand(input int kt, input logic [255:0] k, input bit inj, input int rd_r);
    int n;
    int exp_n;
    exp_n = 4 * (kt * 2 + 4 + 7) - (kt * 2 + 4) + 1;
    @(negedge clk);
    start    = 1'b1;
    key_type = 2'(kt);
    key      = k;
    if (rd_r >= 0) begin
      rk_rd_en    = 1'b1;
      rk_rd_round = 4'(rd_r);
      rdq.push_back('{exp: exp_round(rd_r), mask: FULL, nm: "rd_with_start"});
    end
    @(negedge clk);
    start    = 1'b0;
    rk_rd_en = 1'b0;
    chk("busy_rise", busy, 1);
    chk("done_clear", done, 0);
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (inj && n == 5) begin
        start    = 1'b1;
        key_type = 2'($urandom_range(0, 3));
        key      = {8{$urandom}};
      end else begin
        start = 1'b0;
      end
      if (inj && n == 6) chk("no_err_in_expand", key_err, 0);
    end
    chk("done_cycles", n, exp_n);
    chk("busy_fall", busy, 0);
    model_expand(kt, k);
  endtask

  logic [255:0] k128, k192, k256, kr;
  int order [16];

  initial begin
    k128 = {128'h0, 32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
    k192 = {64'h0, 32'h522c6b7b, 32'h62f8ead2, 32'h809079e5, 32'hc810f32b,
            32'hda0e6452, 32'h8e73b0f7};
    k256 = {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
            32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_key_err", key_err, 0);
    chk("rst_valid", rk_rd_valid, 0);
    chk("rst_data", rk_rd_data, 0);
    rd_blocked("rd_blocked_idle");

    // AES-128 A.1
    do_expand(0, k128, 1'b0, -1);
    rd_issue(1, {96'h0, 32'ha0fafe17}, {96'h0, 32'hffffffff}, "a1_w4");
    rd_issue(10, {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8}, FULL, "a1_round10");
    rd_issue(11, '0, FULL, "a1_round11_zero");
    rd_issue(0, exp_round(0), FULL, "a1_round0");
    rd_stop();

    // illegal key type in DONE
    @(negedge clk);
    start    = 1'b1;
    key_type = 2'd3;
    @(negedge clk);
    start = 1'b0;
    chk("kerr_pulse", key_err, 1);
    chk("kerr_done_kept", done, 1);
    @(negedge clk);
    chk("kerr_single", key_err, 0);
    chk("kerr_done_still", done, 1);
    rd_issue(10, {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8}, FULL, "kerr_old_rk");
    rd_stop();

    // AES-192 A.2, with a read issued alongside the start
    do_expand(1, k192, 1'b1, 10);
    rd_issue(1, {32'h0, 32'hfe0c91f7, 64'h0}, {32'h0, 32'hffffffff, 64'h0}, "a2_w6");
    rd_issue(12, {32'h01002202, 96'h0}, {32'hffffffff, 96'h0}, "a2_w51");
    rd_issue(13, '0, FULL, "a2_round13_zero");
    rd_stop();

    // AES-256 A.3
    do_expand(2, k256, 1'b1, 5);
    rd_issue(2, {96'h0, 32'h9ba35411}, {96'h0, 32'hffffffff}, "a3_w8");
    rd_issue(14, {32'h706c631e, 96'h0}, {32'hffffffff, 96'h0}, "a3_w59");
    for (int r = 0; r < 16; r++) rd_issue(r, exp_round(r), FULL, "a3_all");
    rd_stop();

    // reset mid-expansion
    @(negedge clk);
    start    = 1'b1;
    key_type = 2'd0;
    key      = {8{$urandom}};
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_valid", rk_rd_valid, 0);
    rd_blocked("rd_blocked_after_rst");
    do_expand(0, k128, 1'b0, -1);
    rd_issue(10, {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8}, FULL, "rst_a1_round10");
    rd_stop();

    // randomized schedules
    for (int it = 0; it < 8; it++) begin
      for (int j = 0; j < 8; j++) kr[32*j +: 32] = $urandom;
      do_expand($urandom_range(0, 2), kr, 1'($urandom_range(0, 1)), -1);
      for (int j = 0; j < 16; j++) order[j] = j;
      for (int j = 15; j > 0; j--) begin
        int s, t;
        s = $urandom_range(0, j);
        t = order[j];
        order[j] = order[s];
        order[s] = t;
      end
      for (int j = 0; j < 16; j++) begin
        rd_issue(order[j], exp_round(order[j]), FULL, "rand_round");
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clk);
          rk_rd_en = 1'b0;
        end
      end
      rd_stop();
    end

    repeat (3) @(negedge clk);
    chk("rdq_drained", 128'(rdq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_expansion_sequencer.md
# key_expansion_sequencer

Iterative AES key-expansion controller for 128/192/256-bit keys. It time-shares one 4-S-box SubWord datapath to generate one schedule word per cycle into an internal 60-word store. Once expansion completes, it serves 128-bit round keys to the cipher round controller through a registered read port.

## Interface

- No parameters; all sizing is fixed by the AES standard.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to expand `key`
- key_type  in  2  0=AES-128 (Nk=4, Nr=10), 1=AES-192 (Nk=6, Nr=12), 2=AES-256 (Nk=8, Nr=14); 3 is illegal
- key  in  256  word i of the cipher key in key[32i+:32]; only the low 32·Nk bits are used
- busy  out  1  expansion in progress
- done  out  1  schedule valid; held until the next accepted start or rst
- key_err  out  1  one-cycle pulse when start arrives with key_type=3
- rk_rd_en  in  1  round-key read request
- rk_rd_round  in  4  round index 0..Nr
- rk_rd_valid  out  1  read response strobe
- rk_rd_data  out  128  {w[4r+3], w[4r+2], w[4r+1], w[4r]}

One clock; reset is synchronous and active-high.

## Operation

- States: IDLE, EXPAND, DONE.
- Word byte order: bits [31:24] hold FIPS byte a0.
  - RotWord(x) = {x[23:0], x[31:24]}.
  - Rcon is XORed into bits [31:24].
- Start acceptance:
  - start is accepted only in IDLE or DONE, with key_type≠3.
  - On acceptance: latch Nk and Nr, write w[0..Nk-1] from key, set word index i=Nk and rcon=8'h01, then enter EXPAND.
- start with key_type=3 in IDLE/DONE:
  - key_err pulses.
  - The state is unchanged, and done keeps its value.
- start while in EXPAND is ignored silently.
- Each EXPAND cycle computes one word w[i] = w[i-Nk] ^ temp, where:
  - i mod Nk = 0: temp = SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}, then rcon ← xtime(rcon) (01, 02, …, 80, 1B, 36).
  - Nk=8 and i mod 8 = 4: temp = SubWord(w[i-1]).
  - Otherwise: temp = w[i-1].
- After writing word 4(Nr+1)-1 (w43, w51 or w59): go to DONE.
- The SubWord input mux selects RotWord(w[i-1]) or w[i-1]. It is a single shared instance.
- Reads:
  - A read is honoured only in DONE.
  - rk_rd_en in any other state gives no rk_rd_valid.
  - rk_rd_round > Nr returns rk_rd_valid=1 with rk_rd_data=0.
- rst at any time, including mid-EXPAND:
  - Go to IDLE; busy, done, key_err and rk_rd_valid all 0.
  - The word store is not cleared, but reads stay blocked until the next DONE.

## Timing

- Reset values: busy=0, done=0, key_err=0, rk_rd_valid=0, rk_rd_data=0.
- start accepted in cycle T:
  - busy=1 from T+1.
  - w[Nk] is written at the end of T+1.
  - One word is written per cycle.
- Expansion cycle counts and done timing:
  - AES-128: 40 EXPAND cycles; busy falls and done rises at T+41.
  - AES-192: 46 cycles; done at T+47.
  - AES-256: 52 cycles; done at T+53.
- A start accepted in DONE clears done at T+1.
- key_err is high in cycle T+1 only.
- Read port:
  - Request in cycle R gives rk_rd_valid and rk_rd_data in R+1 (1-cycle latency).
  - Back-to-back reads are supported every cycle.
  - rk_rd_data holds its last value when rk_rd_valid=0.
- start and rk_rd_en together in DONE: the read is served from the old schedule in R+1; the start is accepted normally.

## Structure

- Package aes_key_pkg:
  - key_type encodings (KT_128, KT_192, KT_256).
  - Constant functions nk_of and nr_of.
  - TOTAL_WORDS_MAX=60.
  - xtime function for the rcon update.
- Sub-module: the existing four-S-box subWord block, instantiated exactly once.
- Word store: 60×32 register array, with one write port (EXPAND) and four read taps (w[i-1], w[i-Nk], round read).

## Test plan

- AES-128 FIPS-197 A.1: key w0..w3 = 2b7e1516, 28aed2a6, abf71588, 09cf4f3c.
  - w4 = a0fafe17, w43 = b6630ca6; done at T+41.
  - Read round 10 gives {b6630ca6, e13f0cc8, c9ee2589, d014f9a8}.
- AES-192 A.2: key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b.
  - w6 = fe0c91f7, w51 = 01002202; done at T+47.
- AES-256 A.3: key 603deb10 … 0914dff4.
  - w8 = 9ba35411, w59 = 706c631e; done at T+53; exercises the i mod 8 = 4 SubWord path.
- start with key_type=3 in DONE:
  - key_err pulses once; done stays 1; old round keys are readable unchanged.
- Reset during EXPAND, then start again:
  - busy=0, done=0 the cycle after rst; rk_rd_en gives no valid.
  - A new AES-128 start yields correct w43 at T+41.
- Read handling:
  - Read round 11 under AES-128 gives valid=1, data=0.
  - start during EXPAND is ignored; done timing is unchanged.
